// File: rtl/types.sv
// Shared NoC flit type used by the arbiter and its neighbours.
package types;
    typedef logic [15:0] flit_t;
endpackage

// File: rtl/flit_arbiter_ctrl.sv
// Two-source packet arbiter feeding a single registered flit output.
// System traffic has priority, but a waiting normal source gets a bounded share.
module flit_arbiter_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         nocclk,
    input  logic         rst_n,
    input  types::flit_t in_system_flit,
    input  logic         in_system_valid,
    input  logic         in_system_tail,
    output logic         in_system_ready,
    input  types::flit_t in_normal_flit,
    input  logic         in_normal_valid,
    input  logic         in_normal_tail,
    output logic         in_normal_ready,
    output types::flit_t out_flit,
    output logic         out_flit_valid,
    input  logic         out_flit_ready
);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StLockSys, StLockNrm} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_starve_cnt;
    logic [CntW-1:0] w_starve_next;
    types::flit_t    r_out_flit;
    logic            r_out_valid;

    logic            w_load;
    logic            w_grant_sys;
    logic            w_grant_nrm;
    logic            w_xfer_sys;
    logic            w_xfer_nrm;
    logic            w_xfer;
    logic            w_tail;
    logic            w_starved;
    types::flit_t    w_flit;

    assign w_load    = !r_out_valid || out_flit_ready;
    assign w_starved = (r_starve_cnt == CntW'(STARVE_LIMIT));

    always_comb begin
        w_grant_sys = 1'b0;
        w_grant_nrm = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_system_valid && in_normal_valid) begin
                    w_grant_nrm = w_starved;
                    w_grant_sys = !w_starved;
                end else begin
                    w_grant_sys = in_system_valid;
                    w_grant_nrm = in_normal_valid;
                end
            end
            StLockSys: w_grant_sys = in_system_valid;
            StLockNrm: w_grant_nrm = in_normal_valid;
            default: ;
        endcase
    end

    // Readys are gated by reset so nothing is accepted while the block is held.
    assign in_system_ready = rst_n && w_load && w_grant_sys;
    assign in_normal_ready = rst_n && w_load && w_grant_nrm;

    assign w_xfer_sys = in_system_ready;
    assign w_xfer_nrm = in_normal_ready;
    assign w_xfer     = w_xfer_sys || w_xfer_nrm;
    assign w_tail     = w_xfer_sys ? in_system_tail : in_normal_tail;
    assign w_flit     = w_xfer_sys ? in_system_flit : in_normal_flit;

    always_comb begin
        w_state_next = r_state;
        if (w_xfer) begin
            if (w_tail) begin
                w_state_next = StIdle;
            end else if (w_xfer_sys) begin
                w_state_next = StLockSys;
            end else begin
                w_state_next = StLockNrm;
            end
        end
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!in_normal_valid || (w_xfer_nrm && in_normal_tail)) begin
            w_starve_next = '0;
        end else if (w_xfer_sys && in_system_tail && !w_starved) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // A load with no transfer drains the register but keeps the old flit value.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_flit <= w_flit;
            end
        end
    end

    assign out_flit       = r_out_flit;
    assign out_flit_valid = r_out_valid;

endmodule

// File: tb/tb_flit_arbiter_ctrl.sv
// Directed bench for flit_arbiter_ctrl: queued source drivers, an expected-flit
// scoreboard popped by an output monitor, and point checks on handshakes.
module tb_flit_arbiter_ctrl;
    typedef struct {
        types::flit_t flit;
        logic         tail;
        int           gap;
    } ent_t;

    logic         nocclk;
    logic         rst_n;
    types::flit_t in_system_flit;
    logic         in_system_valid;
    logic         in_system_tail;
    logic         in_system_ready;
    types::flit_t in_normal_flit;
    logic         in_normal_valid;
    logic         in_normal_tail;
    logic         in_normal_ready;
    types::flit_t out_flit;
    logic         out_flit_valid;
    logic         out_flit_ready;

    ent_t         src_q[2][$];
    types::flit_t exp_q[$];
    int           vectors;
    int           miscompares;

    flit_arbiter_ctrl #(.STARVE_LIMIT(4)) dut (
        .nocclk          (nocclk),
        .rst_n           (rst_n),
        .in_system_flit  (in_system_flit),
        .in_system_valid (in_system_valid),
        .in_system_tail  (in_system_tail),
        .in_system_ready (in_system_ready),
        .in_normal_flit  (in_normal_flit),
        .in_normal_valid (in_normal_valid),
        .in_normal_tail  (in_normal_tail),
        .in_normal_ready (in_normal_ready),
        .out_flit        (out_flit),
        .out_flit_valid  (out_flit_valid),
        .out_flit_ready  (out_flit_ready)
    );

    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add(input int src, input types::flit_t f, input logic t, input int gap);
        ent_t e;
        e.flit = f;
        e.tail = t;
        e.gap  = gap;
        src_q[src].push_back(e);
    endtask

    task automatic expect_flit(input types::flit_t f);
        exp_q.push_back(f);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge nocclk);
            n++;
        end while (!(exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0
                     && !out_flit_valid) && n < budget);
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d flits still expected after %0d cycles",
                     exp_q.size(), n);
            exp_q.delete();
            src_q[0].delete();
            src_q[1].delete();
        end
    endtask

    // Source drivers: hold each queued flit until accepted, optional idle gap before it.
    initial begin
        bit xfer[2];
        bit loaded[2];
        bit vld[2];
        int gap_left[2];
        for (int i = 0; i < 2; i++) begin
            loaded[i]   = 1'b0;
            gap_left[i] = 0;
        end
        in_system_valid = 1'b0;
        in_system_flit  = '0;
        in_system_tail  = 1'b0;
        in_normal_valid = 1'b0;
        in_normal_flit  = '0;
        in_normal_tail  = 1'b0;
        forever begin
            @(negedge nocclk);
            xfer[0] = in_system_valid && in_system_ready;
            xfer[1] = in_normal_valid && in_normal_ready;
            @(posedge nocclk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (xfer[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    loaded[i] = 1'b0;
                end
                if (src_q[i].size() == 0) begin
                    loaded[i] = 1'b0;
                end else if (!loaded[i]) begin
                    loaded[i]   = 1'b1;
                    gap_left[i] = src_q[i][0].gap;
                end
                if (loaded[i] && gap_left[i] > 0) begin
                    vld[i] = 1'b0;
                    gap_left[i]--;
                end else begin
                    vld[i] = loaded[i];
                end
            end
            in_system_valid = vld[0];
            in_system_flit  = loaded[0] ? src_q[0][0].flit : '0;
            in_system_tail  = loaded[0] ? src_q[0][0].tail : 1'b0;
            in_normal_valid = vld[1];
            in_normal_flit  = loaded[1] ? src_q[1][0].flit : '0;
            in_normal_tail  = loaded[1] ? src_q[1][0].tail : 1'b0;
        end
    end

    always @(negedge nocclk) begin
        if (rst_n && out_flit_valid && out_flit_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_unexpected: got %0h, required no flit", out_flit);
            end else begin
                chk("out_flit", {16'h0, out_flit}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int s;
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        out_flit_ready = 1'b0;

        // Starvation rotation: all single-flit packets, both sources busy.
        @(negedge nocclk);
        for (int i = 0; i < 10; i++) add(0, 16'h1000 + 16'(i), 1'b1, 0);
        for (int i = 0; i < 3; i++) add(1, 16'h2000 + 16'(i), 1'b1, 0);
        s = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (s < 10) begin
                    expect_flit(16'h1000 + 16'(s));
                    s++;
                end
            end
            expect_flit(16'h2000 + 16'(k));
        end
        @(negedge nocclk);
        chk("rst_out_valid", {31'h0, out_flit_valid}, 32'h0);
        chk("rst_out_flit", {16'h0, out_flit}, 32'h0);
        chk("rst_sys_ready", {31'h0, in_system_ready}, 32'h0);
        chk("rst_nrm_ready", {31'h0, in_normal_ready}, 32'h0);
        @(posedge nocclk);
        #1;
        rst_n          = 1'b1;
        out_flit_ready = 1'b1;
        drain(200);

        // Normal packet holds the lock against a later system request.
        add(1, 16'h3001, 1'b0, 0);
        add(1, 16'h3002, 1'b0, 0);
        add(1, 16'h3003, 1'b1, 0);
        add(0, 16'h3100, 1'b1, 1);
        expect_flit(16'h3001);
        expect_flit(16'h3002);
        expect_flit(16'h3003);
        expect_flit(16'h3100);
        @(negedge nocclk);
        @(negedge nocclk);
        chk("lock_nrm_sys_ready", {31'h0, in_system_ready}, 32'h0);
        drain(200);

        // Backpressure inside a system lock with a normal flit waiting.
        add(0, 16'h4001, 1'b0, 0);
        add(0, 16'h4002, 1'b0, 0);
        add(0, 16'h4003, 1'b0, 0);
        add(0, 16'h4004, 1'b1, 0);
        add(1, 16'h4100, 1'b1, 0);
        for (int i = 1; i <= 4; i++) expect_flit(16'h4000 + 16'(i));
        expect_flit(16'h4100);
        repeat (3) @(posedge nocclk);
        #1;
        out_flit_ready = 1'b0;
        repeat (5) begin
            @(negedge nocclk);
            chk("stall_sys_ready", {31'h0, in_system_ready}, 32'h0);
            chk("stall_nrm_ready", {31'h0, in_normal_ready}, 32'h0);
            chk("stall_out_valid", {31'h0, out_flit_valid}, 32'h1);
            chk("stall_out_flit", {16'h0, out_flit}, 32'h4002);
        end
        @(posedge nocclk);
        #1;
        out_flit_ready = 1'b1;
        @(negedge nocclk);
        chk("resume_sys_ready", {31'h0, in_system_ready}, 32'h1);
        drain(200);

        // Normal-only traffic with a one-cycle valid gap.
        add(1, 16'h5000, 1'b1, 0);
        add(1, 16'h5001, 1'b1, 1);
        add(1, 16'h5002, 1'b1, 0);
        expect_flit(16'h5000);
        expect_flit(16'h5001);
        expect_flit(16'h5002);
        @(negedge nocclk);
        chk("nrm_only_ready", {31'h0, in_normal_ready}, 32'h1);
        @(negedge nocclk);
        chk("latency_valid", {31'h0, out_flit_valid}, 32'h1);
        chk("latency_flit", {16'h0, out_flit}, 32'h5000);
        repeat (4) begin
            @(negedge nocclk);
            chk("starve_cnt_zero", 32'(dut.r_starve_cnt), 32'h0);
        end
        drain(200);

        // Reset in the middle of a system packet.
        add(0, 16'h6000, 1'b0, 0);
        add(0, 16'h6001, 1'b0, 0);
        add(0, 16'h6002, 1'b0, 0);
        add(0, 16'h6003, 1'b1, 0);
        expect_flit(16'h6000);
        repeat (3) @(posedge nocclk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_flit_valid}, 32'h0);
        chk("midrst_out_flit", {16'h0, out_flit}, 32'h0);
        chk("midrst_sys_ready", {31'h0, in_system_ready}, 32'h0);
        @(negedge nocclk);
        src_q[0].delete();
        add(1, 16'h6100, 1'b1, 0);
        expect_flit(16'h6100);
        @(posedge nocclk);
        #2;
        chk("midrst_nrm_ready", {31'h0, in_normal_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge nocclk);
        chk("postrst_nrm_ready", {31'h0, in_normal_ready}, 32'h1);
        @(negedge nocclk);
        chk("postrst_out_valid", {31'h0, out_flit_valid}, 32'h1);
        chk("postrst_out_flit", {16'h0, out_flit}, 32'h6100);
        drain(200);

        // Both multi-flit packets start together: system locks first.
        add(0, 16'h7000, 1'b0, 0);
        add(0, 16'h7001, 1'b1, 0);
        add(1, 16'h7100, 1'b0, 0);
        add(1, 16'h7101, 1'b1, 0);
        expect_flit(16'h7000);
        expect_flit(16'h7001);
        expect_flit(16'h7100);
        expect_flit(16'h7101);
        @(negedge nocclk);
        chk("both_sys_ready", {31'h0, in_system_ready}, 32'h1);
        chk("both_nrm_ready", {31'h0, in_normal_ready}, 32'h0);
        @(negedge nocclk);
        chk("locksys_sys_ready", {31'h0, in_system_ready}, 32'h1);
        chk("locksys_nrm_ready", {31'h0, in_normal_ready}, 32'h0);
        @(negedge nocclk);
        chk("after_tail_nrm_ready", {31'h0, in_normal_ready}, 32'h1);
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flit_arbiter_ctrl.md
FLIT_ARBITER_CTRL -- requirements
Module: flit_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive system-packet grants allowed while a normal flit waits.
REQ-002 nocclk  input  1  NoC clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_system_flit  input  types::flit_t  system-source flit.
REQ-005 in_system_valid  input  1  system flit present.
REQ-006 in_system_tail  input  1  system flit is the last of its packet.
REQ-007 in_system_ready  output  1  system flit accepted this cycle.
REQ-008 in_normal_flit  input  types::flit_t  normal-source flit.
REQ-009 in_normal_valid  input  1  normal flit present.
REQ-010 in_normal_tail  input  1  normal flit is the last of its packet.
REQ-011 in_normal_ready  output  1  normal flit accepted this cycle.
REQ-012 out_flit  output  types::flit_t  registered granted flit, fed to the checksum stage.
REQ-013 out_flit_valid  output  1  out_flit holds a valid flit.
REQ-014 out_flit_ready  input  1  downstream consumes out_flit this cycle.

Function
REQ-015 The output register SHALL be loadable in a cycle ("load") exactly when out_flit_valid=0 or out_flit_ready=1.
REQ-016 An input transfer SHALL occur only when its valid=1, its ready=1 and load=1.
REQ-017 At most one ready SHALL be 1 per cycle, and a ready SHALL be asserted only when load=1 and that source holds the grant.
REQ-018 Each ready SHALL be a combinational function of the current state, both valids and out_flit_ready.
REQ-019 The FSM SHALL have states IDLE, LOCK_SYS and LOCK_NRM.
REQ-020 In IDLE, the system source SHALL win when both sources are valid, unless starve_cnt equals STARVE_LIMIT, in which case the normal source SHALL win.
REQ-021 In IDLE with a single valid source, that source SHALL be granted.
REQ-022 In LOCK_SYS only the system source SHALL be grantable, and in LOCK_NRM only the normal source SHALL be grantable; the other source's valid SHALL be ignored.
REQ-023 A transfer with tail=0 SHALL move the FSM to the lock state of the granted source, or keep it there if already locked.
REQ-024 A transfer with tail=1 SHALL return the FSM to IDLE.
REQ-025 With no transfer, the FSM state SHALL be unchanged.
REQ-026 A single-flit packet (tail=1 granted in IDLE) SHALL leave the FSM in IDLE.
REQ-027 starve_cnt SHALL be internal, 0..STARVE_LIMIT, with width $clog2(STARVE_LIMIT+1).
REQ-028 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each system tail transfer while in_normal_valid=1.
REQ-029 starve_cnt SHALL clear to 0 on any normal tail transfer, and SHALL also clear to 0 when in_normal_valid=0.
REQ-030 On a transfer, out_flit SHALL take the granted flit unmodified, and out_flit_valid SHALL be 1 in the next cycle.
REQ-031 When load=1 with no transfer, out_flit_valid SHALL go to 0 in the next cycle and out_flit SHALL hold its value.
REQ-032 When load=0, out_flit and out_flit_valid SHALL hold.
REQ-033 Latency SHALL be one cycle from input transfer to out_flit_valid, and throughput SHALL be one flit per cycle when out_flit_ready=1 continuously.
REQ-034 Under out_flit_ready=0 backpressure in a lock state, no flit of the other source SHALL be accepted, and the pending flit SHALL remain stable.

Reset
REQ-035 While rst_n=0, the block SHALL force FSM=IDLE, starve_cnt=0, out_flit_valid=0, out_flit=0, in_system_ready=0 and in_normal_ready=0.
REQ-036 Reset asserted mid-packet SHALL abandon the lock, and after release arbitration SHALL restart from IDLE with no partial flit emitted.

Verification
REQ-037 Both sources valid, all tails=1, out_flit_ready=1, STARVE_LIMIT=4 -> output sequence S,S,S,S,N,S,S,S,S,N,...
REQ-038 Normal 3-flit packet starts (tail=0,0,1), system valid raised after flit 1 -> N1,N2,N3 emitted contiguously, then S.
REQ-039 out_flit_ready=0 for 5 cycles with out_flit_valid=1 -> both readys=0, out_flit stable, and transfers resume on the first ready cycle.
REQ-040 Only the normal source valid, single-flit packets, with in_normal_valid dropped for 1 cycle -> every flit passes in order with 1-cycle latency and starve_cnt stays 0.
REQ-041 rst_n pulsed low during LOCK_SYS after 2 of 4 flits -> out_flit_valid=0 immediately, and after release a pending normal flit is granted first if the system source is invalid.
REQ-042 Both sources valid simultaneously in IDLE with tail=0 on both -> system granted, FSM=LOCK_SYS, and in_normal_ready=0 until the system tail is transferred.
